// File: rtl/weight_sequencer.sv
// Weight sequencer: streams a weight set into a block RAM (LOAD) and replays it
// to the neuron MAC over a valid/ready stream with neuron-boundary tags (RUN).
module weight_sequencer #(
    parameter int WEIGHT_NUM    = 3,
    parameter int NEURON_NUM    = 5,
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     loadStart_i,
    input  logic                     runStart_i,
    input  logic                     ldValid_i,
    input  logic [DATA_WIDTH-1:0]    ldData_i,
    output logic                     ldReady_o,
    output logic                     wen_o,
    output logic [ADDRESS_WIDTH-1:0] wAdd_o,
    output logic [DATA_WIDTH-1:0]    wIn_o,
    output logic                     ren_o,
    output logic [ADDRESS_WIDTH-1:0] rAdd_o,
    input  logic [DATA_WIDTH-1:0]    wOut_i,
    output logic                     wValid_o,
    output logic [DATA_WIDTH-1:0]    wData_o,
    output logic                     wLast_o,
    output logic [ADDRESS_WIDTH-1:0] wNeuron_o,
    input  logic                     wReady_i,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int TOTAL = WEIGHT_NUM * NEURON_NUM;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR   = ADDRESS_WIDTH'(TOTAL - 1);
    localparam logic [ADDRESS_WIDTH:0]   TOTAL_CNT   = (ADDRESS_WIDTH+1)'(TOTAL);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_WORD   = ADDRESS_WIDTH'(WEIGHT_NUM - 1);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_NEURON = ADDRESS_WIDTH'(NEURON_NUM - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] ld_addr_q, ld_addr_d;
    logic                     wen_q, wen_d;
    logic [ADDRESS_WIDTH-1:0] wadd_q, wadd_d;
    logic [DATA_WIDTH-1:0]    win_q, win_d;
    logic                     done_q, done_d;
    logic [ADDRESS_WIDTH:0]   rd_cnt_q, rd_cnt_d;
    logic                     inflight_q;
    logic [DATA_WIDTH-1:0]    fifo_q [2];
    logic [DATA_WIDTH-1:0]    fifo_d [2];
    logic [1:0]               count_q, count_d;
    logic [ADDRESS_WIDTH-1:0] word_q, word_d;
    logic [ADDRESS_WIDTH-1:0] neuron_q, neuron_d;

    logic       push, pop, issue, last_beat;
    logic [2:0] pending;

    // A read issued now lands in the FIFO two edges later, so it must count
    // against the space left after this cycle's in-flight word and pop.
    assign push      = inflight_q;
    assign wValid_o  = (count_q != 2'd0);
    assign pop       = wValid_o && wReady_i;
    assign pending   = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    assign issue     = (state_q == S_RUN) && (rd_cnt_q < TOTAL_CNT) && (pending < 3'd2);
    assign last_beat = (word_q == LAST_WORD) && (neuron_q == LAST_NEURON);

    assign ren_o     = issue;
    assign rAdd_o    = issue ? rd_cnt_q[ADDRESS_WIDTH-1:0] : '0;
    assign ldReady_o = (state_q == S_LOAD);
    assign busy_o    = (state_q != S_IDLE);
    assign wen_o     = wen_q;
    assign wAdd_o    = wadd_q;
    assign wIn_o     = win_q;
    assign done_o    = done_q;
    assign wData_o   = wValid_o ? fifo_q[0] : '0;
    assign wLast_o   = wValid_o && (word_q == LAST_WORD);
    assign wNeuron_o = wValid_o ? neuron_q : '0;

    always_comb begin
        // NOTE: every _d gets its default first, so no path can infer a latch.
        fifo_d  = fifo_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) fifo_d[0] = wOut_i;
                else                 fifo_d[1] = wOut_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                fifo_d[0] = fifo_q[1];
                count_d   = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    fifo_d[0] = wOut_i;
                end else begin
                    fifo_d[0] = fifo_q[1];
                    fifo_d[1] = wOut_i;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ld_addr_d = ld_addr_q;
        wen_d     = 1'b0;
        wadd_d    = wadd_q;
        win_d     = win_q;
        done_d    = 1'b0;
        rd_cnt_d  = rd_cnt_q;
        word_d    = word_q;
        neuron_d  = neuron_q;
        case (state_q)
            S_IDLE: begin
                if (loadStart_i) begin
                    state_d   = S_LOAD;
                    ld_addr_d = '0;
                end else if (runStart_i) begin
                    state_d  = S_RUN;
                    rd_cnt_d = '0;
                    word_d   = '0;
                    neuron_d = '0;
                end
            end
            S_LOAD: begin
                if (ldValid_i) begin
                    wen_d  = 1'b1;
                    wadd_d = ld_addr_q;
                    win_d  = ldData_i;
                    if (ld_addr_q == LAST_ADDR) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ld_addr_d = ld_addr_q + ADDRESS_WIDTH'(1);
                    end
                end
            end
            S_RUN: begin
                if (issue) rd_cnt_d = rd_cnt_q + (ADDRESS_WIDTH+1)'(1);
                // Tags follow accepted beats, independent of read-side progress.
                if (pop) begin
                    if (last_beat) begin
                        state_d  = S_IDLE;
                        done_d   = 1'b1;
                        word_d   = '0;
                        neuron_d = '0;
                    end else if (word_q == LAST_WORD) begin
                        word_d   = '0;
                        neuron_d = neuron_q + ADDRESS_WIDTH'(1);
                    end else begin
                        word_d   = word_q + ADDRESS_WIDTH'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            ld_addr_q  <= '0;
            wen_q      <= 1'b0;
            wadd_q     <= '0;
            win_q      <= '0;
            done_q     <= 1'b0;
            rd_cnt_q   <= '0;
            inflight_q <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            count_q    <= '0;
            word_q     <= '0;
            neuron_q   <= '0;
        end else begin
            state_q    <= state_d;
            ld_addr_q  <= ld_addr_d;
            wen_q      <= wen_d;
            wadd_q     <= wadd_d;
            win_q      <= win_d;
            done_q     <= done_d;
            rd_cnt_q   <= rd_cnt_d;
            inflight_q <= issue;
            fifo_q     <= fifo_d;
            count_q    <= count_d;
            word_q     <= word_d;
            neuron_q   <= neuron_d;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni) assert (!(push && !pop && (count_q == 2'd2)));
    end
`endif

endmodule
